// File: rtl/jzjpcc_muldiv_sequencer.sv
// rtl/jzjpcc_muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer
// One shift-add or restoring-subtract step per clock; stalls execute until the result is ready.
`timescale 1ns/1ps
module jzjpcc_muldiv_sequencer #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        flush,
  output logic        stallExecute,
  output logic        busy,
  output logic        resultValid,
  output logic [31:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Operand decode at issue
  logic        a_signed, b_signed, sign_a, sign_b, is_div;
  logic [31:0] a_mag_in, b_mag_in;
  logic        div_by_zero, div_overflow, early;
  logic [31:0] early_val;

  always_comb begin
    a_signed     = (funct3 == F_MULH) | (funct3 == F_MULHSU) | (funct3 == F_DIV) | (funct3 == F_REM);
    b_signed     = (funct3 == F_MULH) | (funct3 == F_DIV) | (funct3 == F_REM);
    sign_a       = a_signed & operandA[31];
    sign_b       = b_signed & operandB[31];
    a_mag_in     = sign_a ? -operandA : operandA;
    b_mag_in     = sign_b ? -operandB : operandB;
    is_div       = funct3[2];
    div_by_zero  = is_div & (operandB == 32'd0);
    div_overflow = ((funct3 == F_DIV) | (funct3 == F_REM)) &
                   (operandA == 32'h8000_0000) & (operandB == 32'hFFFF_FFFF);
    early        = (EARLY_OUT != 0) & (div_by_zero | div_overflow);
    if (div_by_zero) begin
      early_val = funct3[1] ? operandA : 32'hFFFF_FFFF;
    end else begin
      early_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step
  logic        mul_bit, div_bit, ge;
  logic [4:0]  div_idx;
  logic [32:0] mul_sum, rem_sh, rem_sub;
  logic [31:0] new_rem;
  logic [63:0] acc_step, prod;
  logic [31:0] quo, rem, fin;

  always_comb begin
    mul_bit = b_mag_q[cnt_q];
    div_idx = 5'd31 - cnt_q;
    div_bit = a_mag_q[div_idx];
    mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (mul_bit ? a_mag_q : 32'd0)};
    rem_sh  = {acc_q[63:32], div_bit};
    rem_sub = rem_sh - {1'b0, b_mag_q};
    ge      = (rem_sh >= {1'b0, b_mag_q});
    new_rem = ge ? rem_sub[31:0] : rem_sh[31:0];
    if (funct3_q[2]) begin
      acc_step = {new_rem, acc_q[30:0], ge};
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
    prod = neg_q_q ? -acc_step : acc_step;
    quo  = neg_q_q ? -acc_step[31:0] : acc_step[31:0];
    rem  = neg_r_q ? -acc_step[63:32] : acc_step[63:32];
    if (funct3_q == F_MUL) begin
      fin = prod[31:0];
    end else if (!funct3_q[2]) begin
      fin = prod[63:32];
    end else if (!funct3_q[1]) begin
      fin = quo;
    end else begin
      fin = rem;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            funct3_d = funct3;
            a_mag_d  = a_mag_in;
            b_mag_d  = b_mag_in;
            // A zero divisor must leave the quotient at all-ones regardless of dividend sign
            neg_q_d  = is_div ? ((sign_a ^ sign_b) & (operandB != 32'd0)) : (sign_a ^ sign_b);
            neg_r_d  = sign_a;
            acc_d    = 64'd0;
            cnt_d    = 5'd0;
            if (early) begin
              result_d = early_val;
              state_d  = DONE;
            end else begin
              state_d  = RUN;
            end
          end
        end
        RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = fin;
            state_d  = DONE;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      funct3_q <= 3'd0;
      a_mag_q  <= 32'd0;
      b_mag_q  <= 32'd0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign stallExecute = ((state_q == IDLE) & start & ~flush) | (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign resultValid  = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_jzjpcc_muldiv_sequencer.sv
// tb/tb_jzjpcc_muldiv_sequencer.sv - directed bench for jzjpcc_muldiv_sequencer
// Drives an EARLY_OUT=1 instance and an EARLY_OUT=0 instance with shared operands.
`timescale 1ns/1ps
module tb_jzjpcc_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_e, start_n, flush;
  logic [2:0]  funct3;
  logic [31:0] operandA, operandB;
  logic        stall_e, busy_e, valid_e;
  logic        stall_n, busy_n, valid_n;
  logic [31:0] result_e, result_n;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_e = 32'd0;

  always #5 clock = ~clock;

  jzjpcc_muldiv_sequencer dut_fast (
    .clock(clock), .reset(reset), .start(start_e), .funct3(funct3),
    .operandA(operandA), .operandB(operandB), .flush(flush),
    .stallExecute(stall_e), .busy(busy_e), .resultValid(valid_e), .result(result_e)
  );

  jzjpcc_muldiv_sequencer #(.EARLY_OUT(0)) dut_slow (
    .clock(clock), .reset(reset), .start(start_n), .funct3(funct3),
    .operandA(operandA), .operandB(operandB), .flush(1'b0),
    .stallExecute(stall_n), .busy(busy_n), .resultValid(valid_n), .result(result_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Samples 40 cycle windows after E0; window c lies between edge E(c) and E(c+1)
  task automatic collect(input bit slow, output int stalls, output int valids,
                         output int vidx, output logic [31:0] got);
    stalls = 0; valids = 0; vidx = -1; got = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (slow ? stall_n : stall_e) stalls++;
      if (slow ? valid_n : valid_e) begin
        valids++;
        if (vidx < 0) vidx = c;
        got = slow ? result_n : result_e;
      end
    end
  endtask

  task automatic run_op(input bit slow, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input string tag);
    int stalls, s2, valids, vidx;
    logic [31:0] got;
    @(negedge clock);
    funct3 = f3; operandA = a; operandB = b;
    if (slow) start_n = 1'b1; else start_e = 1'b1;
    #1;
    stalls = (slow ? stall_n : stall_e) ? 1 : 0;
    @(posedge clock); #1;
    start_e = 1'b0; start_n = 1'b0;
    collect(slow, s2, valids, vidx, got);
    stalls += s2;
    check({tag, "/result"}, got, exp);
    check({tag, "/stall_cycles"}, 32'(stalls), 32'(lat));
    check({tag, "/valid_window"}, 32'(vidx), 32'(lat - 1));
    check({tag, "/valid_count"}, 32'(valids), 32'd1);
    if (!slow) last_e = exp;
  endtask

  initial begin
    int stalls, valids, vidx;
    logic [31:0] got;
    bit found;

    reset = 1'b1; start_e = 1'b0; start_n = 1'b0; flush = 1'b0;
    funct3 = 3'd0; operandA = 32'd0; operandB = 32'd0;
    repeat (2) @(negedge clock);
    check("reset/result", result_e, 32'd0);
    check("reset/valid", {31'd0, valid_e}, 32'd0);
    check("reset/busy", {31'd0, busy_e}, 32'd0);
    check("reset/stall", {31'd0, stall_e}, 32'd0);
    reset = 1'b0;

    run_op(1'b0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_op(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
    run_op(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf_early");
    run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf_early");
    run_op(1'b0, 3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1, "divu_z_early");
    run_op(1'b0, 3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1, "remu_z_early");
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1, "div_negz_early");
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, "div_neg");
    run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, "rem_neg");
    run_op(1'b0, 3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");

    run_op(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div_ovf_iter");
    run_op(1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33, "rem_ovf_iter");
    run_op(1'b1, 3'b101, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 33, "divu_z_iter");
    run_op(1'b1, 3'b111, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 33, "remu_z_iter");
    run_op(1'b1, 3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 33, "div_negz_iter");
    run_op(1'b1, 3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 33, "rem_negz_iter");

    // Flush with start on the 10th RUN cycle
    @(negedge clock);
    funct3 = 3'b000; operandA = 32'd5; operandB = 32'd6; start_e = 1'b1;
    @(posedge clock); #1 start_e = 1'b0;
    repeat (9) @(posedge clock);
    #1 flush = 1'b1; start_e = 1'b1;
    #1 check("flush/stall_in_run", {31'd0, stall_e}, 32'd1);
    @(posedge clock); #1;
    flush = 1'b0; start_e = 1'b0;
    check("flush/busy", {31'd0, busy_e}, 32'd0);
    check("flush/stall", {31'd0, stall_e}, 32'd0);
    check("flush/valid", {31'd0, valid_e}, 32'd0);
    check("flush/result_kept", result_e, last_e);
    collect(1'b0, stalls, valids, vidx, got);
    check("flush/no_valid", 32'(valids), 32'd0);
    run_op(1'b0, 3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");

    // Asynchronous reset in the middle of RUN
    @(negedge clock);
    funct3 = 3'b011; operandA = 32'h1111_1111; operandB = 32'h2222_2222; start_e = 1'b1;
    @(posedge clock); #1 start_e = 1'b0;
    repeat (20) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midreset/busy", {31'd0, busy_e}, 32'd0);
    check("midreset/stall", {31'd0, stall_e}, 32'd0);
    check("midreset/valid", {31'd0, valid_e}, 32'd0);
    check("midreset/result", result_e, 32'd0);
    @(negedge clock) reset = 1'b0;
    collect(1'b0, stalls, valids, vidx, got);
    check("midreset/no_valid", 32'(valids), 32'd0);

    // Back-to-back: start held through DONE is only accepted in the following IDLE cycle
    @(negedge clock);
    funct3 = 3'b111; operandA = 32'd100; operandB = 32'd7; start_e = 1'b1;
    @(posedge clock); #1 start_e = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (valid_e) begin
        found = 1'b1;
        break;
      end
    end
    check("b2b/first_valid_seen", {31'd0, found}, 32'd1);
    check("b2b/first_result", result_e, 32'd2);
    funct3 = 3'b101; operandA = 32'd1000; operandB = 32'd10; start_e = 1'b1;
    #1 check("b2b/stall_low_in_done", {31'd0, stall_e}, 32'd0);
    @(posedge clock); #1;
    check("b2b/idle_after_done", {31'd0, busy_e}, 32'd0);
    check("b2b/stall_on_issue", {31'd0, stall_e}, 32'd1);
    @(posedge clock); #1 start_e = 1'b0;
    collect(1'b0, stalls, valids, vidx, got);
    check("b2b/second_result", got, 32'd100);
    check("b2b/second_valid_window", 32'(vidx), 32'd32);
    check("b2b/second_valid_count", 32'(valids), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
